// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption job scheduler: scheduler states,
// the register map of the decryption register file and the cipher select
// codes. key_addr() maps a cipher select onto its key register address.
package decryption_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REJECT,
    WR_SEL,
    WAIT_SEL,
    WR_KEY,
    WAIT_KEY,
    GRANT,
    DRAIN,
    ABORT
  } state_t;

  localparam logic [7:0] ADDR_SELECT      = 8'h00;
  localparam logic [7:0] ADDR_CAESAR_KEY  = 8'h10;
  localparam logic [7:0] ADDR_SCYTALE_KEY = 8'h12;
  localparam logic [7:0] ADDR_ZIGZAG_KEY  = 8'h14;

  localparam logic [1:0] SEL_CAESAR  = 2'd0;
  localparam logic [1:0] SEL_SCYTALE = 2'd1;
  localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
  localparam logic [1:0] SEL_INVALID = 2'd3;

  function automatic logic [7:0] key_addr(input logic [1:0] sel);
    case (sel)
      SEL_CAESAR:  return ADDR_CAESAR_KEY;
      SEL_SCYTALE: return ADDR_SCYTALE_KEY;
      default:     return ADDR_ZIGZAG_KEY;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after ptr, wrapping at NUM_REQ-1.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  IDX_W    highest-priority index for this decision
//   gnt  out NUM_REQ  one-hot winner (all zero when no request)
//   idx  out IDX_W    winner index
//   vld  out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  // Outer loop walks priority order starting at ptr; the inner loop keeps
  // every bit select constant so the search stays a plain mux tree.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vld && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
          vld    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/decryption_job_scheduler.sv
// Job sequencer and arbiter in front of the decryption top level.
// Arbitrates round-robin among NUM_REQ requesters, programs the select and
// key registers for the winning job, grants the data path until the winner
// releases its request, then waits for the datapath to drain.
// Ports:
//   clk_sys, rst           clock, asynchronous active-high reset
//   req/req_sel/req_key    per-requester request, cipher select and key
//   gnt                    one-hot data-path grant
//   active                 high whenever a job is in progress
//   job_done / job_err     one-cycle completion / rejection-or-abort pulses
//   reg_addr/reg_write/reg_read/reg_wdata  register write port (read unused)
//   reg_done / reg_error   register access acknowledge / error
//   dec_busy               OR of decryptor busy flags
module decryption_job_scheduler
  import decryption_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [2*NUM_REQ-1:0]         req_sel,
  input  logic [REG_WIDTH*NUM_REQ-1:0] req_key,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         active,
  output logic                         job_done,
  output logic                         job_err,
  output logic [ADDR_WIDTH-1:0]        reg_addr,
  output logic                         reg_write,
  output logic                         reg_read,
  output logic [REG_WIDTH-1:0]         reg_wdata,
  input  logic                         reg_done,
  input  logic                         reg_error,
  input  logic                         dec_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The write cycle counts toward TIMEOUT, so the last waiting cycle holds
  // TIMEOUT-2 and ABORT lands exactly TIMEOUT cycles after the write.
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 2);

  state_t state, state_nx;

  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     win_next;
  logic [NUM_REQ-1:0]   win_oh;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;
  logic [1:0]           arb_sel;
  logic [REG_WIDTH-1:0] arb_key;
  logic [1:0]           sel_q;
  logic [REG_WIDTH-1:0] key_q;
  logic [3:0]           tmo_cnt;
  logic                 quiet;
  logic                 drain_ok;
  logic                 win_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Select and key of the current arbitration winner.
  always_comb begin
    arb_sel = '0;
    arb_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        arb_sel = req_sel[2*i +: 2];
        arb_key = req_key[REG_WIDTH*i +: REG_WIDTH];
      end
    end
  end

  assign win_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign win_req  = |(req & win_oh);
  // dec_busy must read 0 in this cycle and the one before, both in DRAIN.
  assign drain_ok = !dec_busy && quiet;
  assign active   = (state != IDLE);
  assign reg_read = 1'b0;

  // Control state: FSM, pointer, winner, timeout counter, drain history.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win_idx <= '0;
      win_oh  <= '0;
      tmo_cnt <= '0;
      quiet   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            win_idx <= arb_idx;
            win_oh  <= arb_gnt;
          end
        end
        WR_SEL, WR_KEY:     tmo_cnt <= '0;
        WAIT_SEL, WAIT_KEY: tmo_cnt <= tmo_cnt + 4'd1;
        GRANT:              quiet   <= 1'b0;
        DRAIN:              quiet   <= !dec_busy;
        default: ;
      endcase
      if ((state == REJECT) || (state == ABORT) || ((state == DRAIN) && drain_ok))
        ptr <= win_next;
    end
  end

  // Job payload latched at arbitration; later req_sel/req_key changes are ignored.
  always_ff @(posedge clk_sys) begin
    if ((state == IDLE) && arb_vld) begin
      sel_q <= arb_sel;
      key_q <= arb_key;
    end
  end

  always_comb begin
    state_nx  = state;
    gnt       = '0;
    job_done  = 1'b0;
    job_err   = 1'b0;
    reg_write = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    case (state)
      IDLE: begin
        if (arb_vld)
          state_nx = (arb_sel == SEL_INVALID) ? REJECT : WR_SEL;
      end
      REJECT: begin
        job_err  = 1'b1;
        state_nx = IDLE;
      end
      WR_SEL: begin
        reg_write = 1'b1;
        reg_addr  = ADDR_WIDTH'(ADDR_SELECT);
        reg_wdata = REG_WIDTH'(sel_q);
        state_nx  = WAIT_SEL;
      end
      WAIT_SEL: begin
        // Error wins over a simultaneous done.
        if (reg_error)                state_nx = ABORT;
        else if (reg_done)            state_nx = WR_KEY;
        else if (tmo_cnt == TMO_LAST) state_nx = ABORT;
      end
      WR_KEY: begin
        reg_write = 1'b1;
        reg_addr  = ADDR_WIDTH'(key_addr(sel_q));
        reg_wdata = key_q;
        state_nx  = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (reg_error)                state_nx = ABORT;
        else if (reg_done)            state_nx = GRANT;
        else if (tmo_cnt == TMO_LAST) state_nx = ABORT;
      end
      GRANT: begin
        gnt = win_oh;
        if (!win_req) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_ok) begin
          job_done = 1'b1;
          state_nx = IDLE;
        end
      end
      ABORT: begin
        job_err  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decryption_job_scheduler.sv
// Bench for decryption_job_scheduler: directed jobs, a register-port
// responder, a job-level model (round-robin pick, expected writes, grants and
// outcomes) and a per-cycle compare process against that model.
module tb_decryption_job_scheduler;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_sel;
  logic [63:0] req_key;
  logic [3:0]  gnt;
  logic        active, job_done, job_err;
  logic [7:0]  reg_addr;
  logic        reg_write, reg_read;
  logic [15:0] reg_wdata;
  logic        reg_done, reg_error, dec_busy;

  logic [1:0]  sel_a [4];
  logic [15:0] key_a [4];
  assign req_sel = {sel_a[3], sel_a[2], sel_a[1], sel_a[0]};
  assign req_key = {key_a[3], key_a[2], key_a[1], key_a[0]};

  decryption_job_scheduler dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .req       (req),
    .req_sel   (req_sel),
    .req_key   (req_key),
    .gnt       (gnt),
    .active    (active),
    .job_done  (job_done),
    .job_err   (job_err),
    .reg_addr  (reg_addr),
    .reg_write (reg_write),
    .reg_read  (reg_read),
    .reg_wdata (reg_wdata),
    .reg_done  (reg_done),
    .reg_error (reg_error),
    .dec_busy  (dec_busy)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  // Responder modes: 0 done, 1 error, 2 done+error, 3 silent.
  int sel_mode, key_mode;
  logic bpat [8];
  int blen;

  // Model state and expectations.
  int m_ptr;
  logic [7:0]  exp_wa [$];
  logic [15:0] exp_wd [$];
  logic [3:0]  exp_gnt [$];
  int          exp_evt [$];   // 1 job_done, 2 job_err

  // Observation logs.
  logic [7:0]  wa_log [$];
  logic [15:0] wd_log [$];
  int          wc_log [$];
  logic [3:0]  gnt_log [$];
  int gnt_rise_cyc, gnt_hi, done_cnt, err_cnt, last_done_cyc, last_err_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int o = 0; o < 4; o++)
      if (r[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] kaddr(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h10;
      2'd1:    return 8'h12;
      default: return 8'h14;
    endcase
  endfunction

  task automatic clear_logs();
    wa_log.delete(); wd_log.delete(); wc_log.delete(); gnt_log.delete();
    gnt_rise_cyc = 0; gnt_hi = 0; done_cnt = 0; err_cnt = 0;
    last_done_cyc = 0; last_err_cyc = 0;
  endtask

  task automatic flush_model();
    exp_wa.delete(); exp_wd.delete(); exp_gnt.delete(); exp_evt.delete();
    m_ptr = 0;
  endtask

  // Register-port responder: answers one cycle after each write.
  initial begin
    int m;
    forever begin
      @(negedge clk_sys);
      if (!rst && reg_write) begin
        m = (reg_addr == 8'h00) ? sel_mode : key_mode;
        @(posedge clk_sys); #1;
        if (m == 0) reg_done = 1'b1;
        else if (m == 1) reg_error = 1'b1;
        else if (m == 2) begin reg_done = 1'b1; reg_error = 1'b1; end
        @(posedge clk_sys); #1;
        reg_done = 1'b0;
        reg_error = 1'b0;
      end
    end
  end

  // Compare process.
  initial begin
    logic [3:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(negedge clk_sys);
      if (rst) begin
        prev_gnt = '0;
      end else begin
        check("reg_read_zero", reg_read, 1'b0);
        check("gnt_onehot0", $onehot0(gnt), 1'b1);
        if (gnt != 0) begin
          check("active_with_gnt", active, 1'b1);
          gnt_hi++;
        end
        if (reg_write) begin
          wa_log.push_back(reg_addr); wd_log.push_back(reg_wdata); wc_log.push_back(cyc);
          if (exp_wa.size() == 0) check("unexpected_write", reg_addr, 64'hFFFF);
          else begin
            check("wr_addr", reg_addr, exp_wa.pop_front());
            check("wr_data", reg_wdata, exp_wd.pop_front());
          end
        end
        if (gnt != 0 && prev_gnt == 0) begin
          gnt_log.push_back(gnt);
          gnt_rise_cyc = cyc;
          if (exp_gnt.size() == 0) check("unexpected_gnt", gnt, 0);
          else check("gnt_winner", gnt, exp_gnt.pop_front());
        end
        if (job_done) begin
          done_cnt++; last_done_cyc = cyc;
          if (exp_evt.size() == 0) check("unexpected_job_done", 1, 0);
          else check("outcome_done", 1, exp_evt.pop_front());
        end
        if (job_err) begin
          err_cnt++; last_err_cyc = cyc;
          if (exp_evt.size() == 0) check("unexpected_job_err", 2, 0);
          else check("outcome_err", 2, exp_evt.pop_front());
        end
        prev_gnt = gnt;
      end
    end
  end

  // Predict one job from the current requests and model pointer.
  task automatic start_job(input logic [3:0] add, input int sm, input int km, output int w);
    req = req | add;
    w = pick(req, m_ptr);
    sel_mode = sm;
    key_mode = km;
    if (w < 0) begin
      check("job_has_requester", 0, 1);
      w = 0;
    end else if (sel_a[w] == 2'd3) begin
      exp_evt.push_back(2);
    end else begin
      exp_wa.push_back(8'h00);
      exp_wd.push_back({14'b0, sel_a[w]});
      if (sm != 0) exp_evt.push_back(2);
      else begin
        exp_wa.push_back(kaddr(sel_a[w]));
        exp_wd.push_back(key_a[w]);
        if (km != 0) exp_evt.push_back(2);
        else begin
          exp_gnt.push_back(4'(1 << w));
          exp_evt.push_back(1);
        end
      end
    end
  endtask

  // Run the job to its end; after: 0 drop req[w], 1 re-raise req[w], 2 clear all.
  task automatic finish_job(input int w, input int after);
    bit dropped, ended;
    dropped = 1'b0;
    ended = 1'b0;
    for (int c = 0; c < 300 && !ended; c++) begin
      @(negedge clk_sys);
      if (job_done || job_err) ended = 1'b1;
      else if (gnt != 0 && !dropped) begin
        dropped = 1'b1;
        @(posedge clk_sys); #1;
        req[w] = 1'b0;
        for (int i = 0; i < blen; i++) begin
          @(posedge clk_sys); #1;
          dec_busy = bpat[i];
        end
      end
    end
    check("job_ended_in_budget", ended, 1'b1);
    @(posedge clk_sys); #1;
    dec_busy = 1'b0;
    case (after)
      0:       req[w] = 1'b0;
      1:       req[w] = 1'b1;
      default: req = '0;
    endcase
    m_ptr = (w + 1) % 4;
  endtask

  initial begin
    int w, err_before;
    rst = 1'b1; req = '0; dec_busy = 1'b0; reg_done = 1'b0; reg_error = 1'b0;
    sel_mode = 0; key_mode = 0; blen = 0;
    for (int i = 0; i < 4; i++) begin sel_a[i] = '0; key_a[i] = '0; end
    for (int i = 0; i < 8; i++) bpat[i] = 1'b0;
    flush_model();
    clear_logs();

    // Reset state
    @(negedge clk_sys);
    check("rst_gnt", gnt, 0);
    check("rst_active", active, 0);
    check("rst_job_done", job_done, 0);
    check("rst_job_err", job_err, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    rst = 1'b0;
    @(posedge clk_sys); #1;

    // 1: single job on requester 1, scytale
    sel_a[1] = 2'd1; key_a[1] = 16'h0304;
    clear_logs();
    start_job(4'b0010, 0, 0, w);
    check("t1_winner", w, 1);
    finish_job(w, 0);
    check("t1_nwrites", wa_log.size(), 2);
    if (wa_log.size() == 2) begin
      check("t1_wr0_addr", wa_log[0], 8'h00);
      check("t1_wr0_data", wd_log[0], 16'h0001);
      check("t1_wr1_addr", wa_log[1], 8'h12);
      check("t1_wr1_data", wd_log[1], 16'h0304);
      check("t1_key_after_sel", wc_log[1] - wc_log[0], 2);
      check("t1_gnt_latency", gnt_rise_cyc - wc_log[1], 2);
    end
    check("t1_gnt_value", (gnt_log.size() == 1) ? gnt_log[0] : 4'hF, 4'b0010);
    check("t1_gnt_cycles", gnt_hi, 2);
    check("t1_done_latency", last_done_cyc - gnt_rise_cyc, 3);
    check("t1_done_count", done_cnt, 1);

    // 2: round robin with all four requesting
    @(posedge clk_sys); #1;
    rst = 1'b1;
    flush_model();
    @(posedge clk_sys); #1;
    rst = 1'b0;
    sel_a[0] = 2'd0; sel_a[1] = 2'd1; sel_a[2] = 2'd2; sel_a[3] = 2'd0;
    key_a[0] = 16'h1111; key_a[1] = 16'h2222; key_a[2] = 16'h3333; key_a[3] = 16'h4444;
    clear_logs();
    for (int j = 0; j < 5; j++) begin
      start_job((j == 0) ? 4'b1111 : 4'b0000, 0, 0, w);
      finish_job(w, (j == 4) ? 2 : 1);
    end
    check("t2_ngrants", gnt_log.size(), 5);
    if (gnt_log.size() == 5) begin
      check("t2_gnt0", gnt_log[0], 4'b0001);
      check("t2_gnt1", gnt_log[1], 4'b0010);
      check("t2_gnt2", gnt_log[2], 4'b0100);
      check("t2_gnt3", gnt_log[3], 4'b1000);
      check("t2_gnt4", gnt_log[4], 4'b0001);
    end
    check("t2_done_count", done_cnt, 5);

    // 3: invalid select on requester 2, requester 3 pending
    sel_a[2] = 2'd3; sel_a[3] = 2'd2; key_a[3] = 16'h0A0B;
    clear_logs();
    start_job(4'b1100, 0, 0, w);
    check("t3_reject_winner", w, 2);
    finish_job(w, 0);
    start_job(4'b0000, 0, 0, w);
    check("t3_next_winner", w, 3);
    finish_job(w, 0);
    check("t3_err_count", err_cnt, 1);
    check("t3_done_count", done_cnt, 1);
    check("t3_gnt", (gnt_log.size() == 1) ? gnt_log[0] : 4'hF, 4'b1000);
    check("t3_nwrites", wa_log.size(), 2);
    if (wa_log.size() == 2) begin
      check("t3_first_write_after_reject", wc_log[0] - last_err_cyc, 2);
      check("t3_key_addr", wa_log[1], 8'h14);
      check("t3_key_data", wd_log[1], 16'h0A0B);
    end

    // 4: error answering the key write, then done+error together
    sel_a[0] = 2'd0; key_a[0] = 16'hBEEF;
    clear_logs();
    start_job(4'b0001, 0, 1, w);
    finish_job(w, 0);
    @(negedge clk_sys);
    check("t4a_active_after", active, 0);
    check("t4a_err_count", err_cnt, 1);
    check("t4a_no_gnt", gnt_log.size(), 0);
    check("t4a_err_latency", (wc_log.size() == 2) ? last_err_cyc - wc_log[1] : -1, 2);
    @(posedge clk_sys); #1;
    sel_a[1] = 2'd2; key_a[1] = 16'h5A5A;
    clear_logs();
    start_job(4'b0010, 0, 2, w);
    finish_job(w, 0);
    @(negedge clk_sys);
    check("t4b_active_after", active, 0);
    check("t4b_err_count", err_cnt, 1);
    check("t4b_done_count", done_cnt, 0);
    check("t4b_no_gnt", gnt_log.size(), 0);
    @(posedge clk_sys); #1;

    // 5: no answer to the select write
    sel_a[2] = 2'd1; key_a[2] = 16'h7777;
    clear_logs();
    start_job(4'b0100, 3, 0, w);
    check("t5_winner", w, 2);
    finish_job(w, 0);
    check("t5_nwrites", wa_log.size(), 1);
    check("t5_timeout_cycles", (wc_log.size() == 1) ? last_err_cyc - wc_log[0] : -1, 15);
    check("t5_err_count", err_cnt, 1);

    // 6: drain with dec_busy 1,0,1,0,0
    sel_a[3] = 2'd2; key_a[3] = 16'hC0DE;
    bpat[0] = 1'b1; bpat[1] = 1'b0; bpat[2] = 1'b1; bpat[3] = 1'b0; bpat[4] = 1'b0;
    blen = 5;
    clear_logs();
    start_job(4'b1000, 0, 0, w);
    check("t6_winner", w, 3);
    finish_job(w, 0);
    blen = 0;
    check("t6_drain_latency", last_done_cyc - gnt_rise_cyc, 6);
    check("t6_done_count", done_cnt, 1);

    // 6b: reset during GRANT
    sel_a[1] = 2'd0; key_a[1] = 16'h1234;
    clear_logs();
    start_job(4'b0010, 0, 0, w);
    for (int c = 0; c < 100 && gnt == 0; c++) @(negedge clk_sys);
    check("t6b_gnt_before_reset", gnt, 4'b0010);
    @(posedge clk_sys); #3;
    rst = 1'b1;
    #1;
    check("t6b_async_gnt", gnt, 0);
    check("t6b_async_active", active, 0);
    check("t6b_async_reg_write", reg_write, 0);
    check("t6b_async_job_done", job_done, 0);
    check("t6b_async_job_err", job_err, 0);
    err_before = err_cnt;
    flush_model();
    req = '0;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("t6b_no_err_after_reset", err_cnt, err_before);
    check("t6b_idle_after_reset", active, 0);

    check("left_exp_writes", exp_wa.size(), 0);
    check("left_exp_gnts", exp_gnt.size(), 0);
    check("left_exp_events", exp_evt.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
